// File: rtl/des_perm_pkg.sv
// Shared DES permutation constants, FSM state type and table lookup helper.
// Tables store 1-based DES source bit numbers; element 63 holds output position 0 (DES bit 1).
package des_perm_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_HALF_W  = 32;

    localparam logic [63:0][7:0] IP_TABLE = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
    };

    localparam logic [63:0][7:0] FP_TABLE = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
        8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
        8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
        8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
        8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PERMUTE = 2'd1,
        DONE    = 2'd2
    } perm_state_e;

    // Entry for 0-based DES output position pos (position 0 = MSB).
    function automatic logic [7:0] table_entry(input logic [63:0][7:0] tbl, input logic [5:0] pos);
        return tbl[6'd63 - pos];
    endfunction

endpackage

// File: rtl/des_perm_chunk.sv
// Combinational slice of a DES bit permutation: produces BITS output bits of chunk
// number 'chunk', MSB-first, from the given source block and table.
module des_perm_chunk
    import des_perm_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [DES_BLOCK_W-1:0] src,
    input  logic [5:0]             chunk,
    input  logic [63:0][7:0]       perm_table,
    output logic [BITS-1:0]        bits
);

    logic [5:0] pos_s;
    logic [7:0] entry_s;

    // Gather each output bit of the chunk from its 1-based source position.
    always_comb begin
        bits    = '0;
        pos_s   = 6'd0;
        entry_s = 8'd0;
        for (int j = 0; j < BITS; j++) begin
            pos_s   = chunk * 6'(BITS) + 6'(j);
            entry_s = table_entry(perm_table, pos_s);
            bits[BITS-1-j] = src[6'(8'd64 - entry_s)];
        end
    end

endmodule

// File: rtl/des_initial_permutation.sv
// DES initial permutation, BITS_PER_CYCLE output bits per cycle.
// Optional IP_SELF_CHECK_EN builds an inverse-permutation check that drives check_err.
module des_initial_permutation
    import des_perm_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set,
    input  logic [DES_BLOCK_W-1:0] data_in,
    output logic                   busy,
    output logic                   status,
    output logic [DES_BLOCK_W-1:0] data_out,
    output logic [DES_HALF_W-1:0]  left_out,
    output logic [DES_HALF_W-1:0]  right_out,
    output logic                   check_err
);

    localparam int         N          = DES_BLOCK_W / BITS_PER_CYCLE;
    localparam logic [5:0] LAST_CHUNK = 6'(N - 1);

    perm_state_e              state_r;
    logic [5:0]               counter_r;
    logic [DES_BLOCK_W-1:0]   src_r;
    logic [DES_BLOCK_W-1:0]   dst_r;
    logic [DES_BLOCK_W-1:0]   dst_next_s;
    logic [BITS_PER_CYCLE-1:0] chunk_bits_s;
    logic [5:0]               wpos_s;
    logic                     chk_mismatch_s;

    des_perm_chunk #(.BITS(BITS_PER_CYCLE)) u_ip_chunk (
        .src        (src_r),
        .chunk      (counter_r),
        .perm_table (IP_TABLE),
        .bits       (chunk_bits_s)
    );

    // Merge the current chunk into the partial result.
    always_comb begin
        dst_next_s = dst_r;
        wpos_s     = 6'd0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            wpos_s = counter_r * 6'(BITS_PER_CYCLE) + 6'(j);
            dst_next_s[6'd63 - wpos_s] = chunk_bits_s[BITS_PER_CYCLE-1-j];
        end
    end

`ifdef IP_SELF_CHECK_EN
    logic [DES_BLOCK_W-1:0] inv_s;

    des_perm_chunk #(.BITS(DES_BLOCK_W)) u_fp_check (
        .src        (dst_next_s),
        .chunk      (6'd0),
        .perm_table (FP_TABLE),
        .bits       (inv_s)
    );

    assign chk_mismatch_s = (inv_s != src_r);
`else
    assign chk_mismatch_s = 1'b0;
`endif

    // Control FSM with registered status outputs; a set while permuting is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            counter_r <= 6'd0;
            src_r     <= 64'h0;
            dst_r     <= 64'h0;
            data_out  <= 64'h0;
            busy      <= 1'b0;
            status    <= 1'b0;
            check_err <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (set) begin
                        src_r     <= data_in;
                        counter_r <= 6'd0;
                        dst_r     <= 64'h0;
                        busy      <= 1'b1;
                        status    <= 1'b0;
                        check_err <= 1'b0;
                        state_r   <= PERMUTE;
                    end
                end
                PERMUTE: begin
                    dst_r <= dst_next_s;
                    if (counter_r == LAST_CHUNK) begin
                        data_out  <= dst_next_s;
                        status    <= 1'b1;
                        busy      <= 1'b0;
                        check_err <= chk_mismatch_s;
                        state_r   <= DONE;
                    end else begin
                        counter_r <= counter_r + 6'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    status  <= 1'b0;
                end
            endcase
        end
    end

    assign left_out  = data_out[63:32];
    assign right_out = data_out[31:0];

endmodule
